// File: rtl/vga_console_ctrl.sv
// Terminal-style writer for the text buffer: byte stream in, cursor tracking, CR/LF/BS/FF handling, clear sweep.
// Optional feature macro VGA_CONSOLE_CLEAR_ON_RESET_EN: blank the whole screen right after reset release.
module vga_console_ctrl #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_W     = $clog2(COLS*ROWS),
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        char_i,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  input  logic              clr_i,
  output logic [7:0]        char_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wen_o,
  output logic              busy_o,
  output logic [6:0]        cursor_col_o,
  output logic [4:0]        cursor_row_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [7:0]        CH_CR         = 8'h0D;
  localparam logic [7:0]        CH_LF         = 8'h0A;
  localparam logic [7:0]        CH_BS         = 8'h08;
  localparam logic [7:0]        CH_FF         = 8'h0C;
  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_COL      = 7'(COLS-1);
  localparam logic [4:0]        LAST_ROW      = 5'(ROWS-1);

  state_t              state_q, state_d;
  logic [6:0]          col_q;
  logic [4:0]          row_q;
  logic [ADDR_W-1:0]   row_base_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          char_q;
  logic                wen_q;
  logic                init_pend;
  logic                fire;
  logic                start_clear;
  logic                sweep_done;
  logic [ADDR_W-1:0]   addr_here;
  logic [4:0]          row_next;
  logic [ADDR_W-1:0]   row_base_next;

`ifdef VGA_CONSOLE_CLEAR_ON_RESET_EN
  logic init_pend_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) init_pend_q <= 1'b1;
    else       init_pend_q <= 1'b0;
  end
  assign init_pend = init_pend_q;
`else
  assign init_pend = 1'b0;
`endif

  assign char_ready_o = (state_q == IDLE) & ~clr_i & ~init_pend & ~rst_i;
  assign fire         = char_valid_i & char_ready_o;
  assign addr_here    = row_base_q + ADDR_W'(col_q);

  // row_base tracks row*COLS incrementally so no multiplier is needed
  always_comb begin
    row_next      = row_q + 5'd1;
    row_base_next = row_base_q + COLS_A;
    if (row_q == LAST_ROW) begin
      row_next      = '0;
      row_base_next = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_clear = 1'b0;
    sweep_done  = 1'b0;
    if (state_q == IDLE) begin
      if (clr_i || init_pend || (fire && char_i == CH_FF)) begin
        state_d     = CLEAR;
        start_clear = 1'b1;
      end
    end else begin
      if (addr_q == LAST_ADDR) begin
        state_d    = IDLE;
        sweep_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      char_q     <= '0;
      wen_q      <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      if (start_clear) begin
        addr_q <= '0;
        char_q <= BLANK_CHAR;
        wen_q  <= 1'b1;
      end else if (state_q == CLEAR) begin
        if (sweep_done) begin
          col_q      <= '0;
          row_q      <= '0;
          row_base_q <= '0;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
          char_q <= BLANK_CHAR;
          wen_q  <= 1'b1;
        end
      end else if (fire) begin
        unique case (char_i)
          CH_CR: col_q <= '0;
          CH_LF: begin
            col_q      <= '0;
            row_q      <= row_next;
            row_base_q <= row_base_next;
          end
          CH_BS: begin
            if (col_q != 7'd0) begin
              col_q  <= col_q - 7'd1;
              addr_q <= addr_here - ADDR_W'(1);
              char_q <= BLANK_CHAR;
              wen_q  <= 1'b1;
            end
          end
          default: begin
            addr_q <= addr_here;
            char_q <= char_i;
            wen_q  <= 1'b1;
            if (col_q == LAST_COL) begin
              col_q      <= '0;
              row_q      <= row_next;
              row_base_q <= row_base_next;
            end else begin
              col_q <= col_q + 7'd1;
            end
          end
        endcase
      end
    end
  end

  assign char_o       = char_q;
  assign addr_o       = addr_q;
  assign wen_o        = wen_q;
  assign busy_o       = (state_q == CLEAR);
  assign cursor_col_o = col_q;
  assign cursor_row_o = row_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Self-checking bench for vga_console_ctrl: vector table, hand corner sequences, randomized stream vs model.
module tb_vga_console_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int TOTAL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        clr = 1'b0;
  logic [7:0]  char_out;
  logic [11:0] addr;
  logic        wen;
  logic        busy;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: cursor plus queue of expected writes (addr*256+char)
  int m_col = 0;
  int m_row = 0;
  int exp_q[$];

  vga_console_ctrl dut (
    .clk_i(clk), .rst_i(rst), .char_i(char_in), .char_valid_i(char_valid),
    .char_ready_o(char_ready), .clr_i(clr), .char_o(char_out), .addr_o(addr),
    .wen_o(wen), .busy_o(busy), .cursor_col_o(cur_col), .cursor_row_o(cur_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wen) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_write: got addr %0d char %0h expected no write", addr, char_out);
      end else begin
        int e;
        e = exp_q.pop_front();
        if ((int'(addr) * 256 + int'(char_out)) != e) begin
          n_fail++;
          $display("FAIL write: got addr %0d char %0h expected addr %0d char %0h",
                   addr, char_out, e / 256, e % 256);
        end
      end
    end
  end

  task automatic model_clear();
    for (int a = 0; a < TOTAL; a++) exp_q.push_back(a * 256 + 32'h20);
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (b)
      8'h0D: m_col = 0;
      8'h0A: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      8'h08: if (m_col > 0) begin
        m_col = m_col - 1;
        exp_q.push_back((m_row * COLS + m_col) * 256 + 32'h20);
      end
      8'h0C: model_clear();
      default: begin
        exp_q.push_back((m_row * COLS + m_col) * 256 + int'(b));
        m_col = m_col + 1;
        if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    char_in    = b;
    char_valid = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    char_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // start a clear via clr_i (with a competing byte) or FF, then measure the sweep
  task automatic do_clear(input bit use_ff);
    int bcnt;
    int wcnt;
    if (use_ff) begin
      send(8'h0C);
    end else begin
      clr = 1'b1; char_in = 8'h51; char_valid = 1'b1;
      #1;
      chk("clr_blocks_ready", int'(char_ready), 0);
      model_clear();
      @(posedge clk); #1;
      clr = 1'b0; char_valid = 1'b0;
    end
    bcnt = 0;
    wcnt = 0;
    while (busy && bcnt < TOTAL + 100) begin
      if (wen) wcnt++;
      if (bcnt == 500) chk("ready_low_in_clear", int'(char_ready), 0);
      bcnt++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", bcnt, TOTAL);
    chk("wen_cycles", wcnt, TOTAL);
    chk("wen_drop_with_busy", int'(wen), 0);
    chk("clear_col", int'(cur_col), 0);
    chk("clear_row", int'(cur_row), 0);
    chk("clear_ready", int'(char_ready), 1);
    chk("clear_writes_done", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] ch;
    int         wen;
    int         addr;
    int         dat;
    int         col;
    int         row;
  } vec_t;

  initial begin
    vec_t vt[12];
    int   cnt;

    vt[0]  = '{8'h41, 1, 0,   8'h41, 1, 0};
    vt[1]  = '{8'h42, 1, 1,   8'h42, 2, 0};
    vt[2]  = '{8'h08, 1, 1,   8'h20, 1, 0};
    vt[3]  = '{8'h0D, 0, 0,   0,     0, 0};
    vt[4]  = '{8'h08, 0, 0,   0,     0, 0};
    vt[5]  = '{8'h0A, 0, 0,   0,     0, 1};
    vt[6]  = '{8'h43, 1, 80,  8'h43, 1, 1};
    vt[7]  = '{8'h0A, 0, 0,   0,     0, 2};
    vt[8]  = '{8'h78, 1, 160, 8'h78, 1, 2};
    vt[9]  = '{8'h79, 1, 161, 8'h79, 2, 2};
    vt[10] = '{8'h7A, 1, 162, 8'h7A, 3, 2};
    vt[11] = '{8'h08, 1, 162, 8'h20, 2, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", int'(wen), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_char", int'(char_out), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_row", int'(cur_row), 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", int'(char_ready), 1);

    // back-to-back byte table, one byte per cycle
    for (int i = 0; i < 12; i++) begin
      chk("vec_ready", int'(char_ready), 1);
      send(vt[i].ch);
      chk("vec_wen", int'(wen), vt[i].wen);
      if (vt[i].wen != 0) begin
        chk("vec_addr", int'(addr), vt[i].addr);
        chk("vec_char", int'(char_out), vt[i].dat);
      end
      chk("vec_col", int'(cur_col), vt[i].col);
      chk("vec_row", int'(cur_row), vt[i].row);
    end
    idle_cycle();
    chk("idle_no_wen", int'(wen), 0);

    // bottom-row LF wraps to the top, BS at column 0 is a no-op
    send(8'h0D);
    repeat (27) send(8'h0A);
    repeat (5) send(8'h71);
    chk("pre_lf_col", int'(cur_col), 5);
    chk("pre_lf_row", int'(cur_row), 29);
    send(8'h0A);
    chk("lf_wrap_wen", int'(wen), 0);
    chk("lf_wrap_col", int'(cur_col), 0);
    chk("lf_wrap_row", int'(cur_row), 0);
    send(8'h08);
    chk("bs0_wen", int'(wen), 0);
    chk("bs0_col", int'(cur_col), 0);

    // last-column wrap
    repeat (79) send(8'h61);
    chk("col79", int'(cur_col), 79);
    send(8'h5A);
    chk("z_addr", int'(addr), 79);
    chk("z_col", int'(cur_col), 0);
    chk("z_row", int'(cur_row), 1);
    send(8'h59);
    chk("y_addr", int'(addr), 80);
    chk("y_char", int'(char_out), 8'h59);
    idle_cycle();

    do_clear(1'b0);
    idle_cycle();

    // randomized stream against the model
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 299);
      if (r == 0) begin
        do_clear(1'b0);
      end else if (r == 1) begin
        do_clear(1'b1);
      end else if (r < 60) begin
        idle_cycle();
      end else begin
        logic [7:0] b;
        int k;
        k = $urandom_range(0, 19);
        if (k == 0)      b = 8'h0D;
        else if (k == 1) b = 8'h0A;
        else if (k < 5)  b = 8'h08;
        else             b = 8'($urandom_range(32'h21, 32'h7E));
        chk("rand_ready", int'(char_ready), 1);
        send(b);
        chk("rand_col", int'(cur_col), m_col);
        chk("rand_row", int'(cur_row), m_row);
      end
    end
    idle_cycle();
    chk("rand_writes_done", exp_q.size(), 0);

    // reset in the middle of a sweep
    clr = 1'b1;
    model_clear();
    @(posedge clk); #1;
    clr = 1'b0;
    cnt = 0;
    while (addr != 12'd1000 && cnt < TOTAL + 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("reached_addr_1000", int'(addr), 1000);
    rst = 1'b1;
    #1;
    chk("midrst_wen", int'(wen), 0);
    chk("midrst_busy", int'(busy), 0);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready", int'(char_ready), 1);
    @(posedge clk); #1;
    chk("post_rst_wen", int'(wen), 0);
    chk("post_rst_busy", int'(busy), 0);
    send(8'h4B);
    chk("post_rst_addr", int'(addr), 0);
    chk("post_rst_col", int'(cur_col), 1);
    idle_cycle();
    chk("final_writes_done", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
